// File: rtl/counter_ctrl_pkg.sv
// rtl/counter_ctrl_pkg.sv - shared types for the counter/timer controller
package counter_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } ctrl_state_t;

endpackage

// File: rtl/counter_forward.sv
// rtl/counter_forward.sv - loadable up-counter with all-ones lookahead
// Ports: clk_i clock, arst_i async active-high clear, action_i 1=increment
// 0=load data_i, data_o counter value, will_overflow_o high when data_o is all-ones.
module counter_forward #(
    parameter int WORD_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  arst_i,
    input  logic                  action_i,
    input  logic [WORD_WIDTH-1:0] data_i,
    output logic [WORD_WIDTH-1:0] data_o,
    output logic                  will_overflow_o
);

    localparam logic [WORD_WIDTH-1:0] ONE = {{(WORD_WIDTH-1){1'b0}}, 1'b1};

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            data_o <= '0;
        end else if (action_i) begin
            data_o <= data_o + ONE;
        end else begin
            data_o <= data_i;
        end
    end

    // The next increment would wrap back to zero.
    assign will_overflow_o = &data_o;

endmodule

// File: rtl/counter_timer_ctrl.sv
// rtl/counter_timer_ctrl.sv - one-shot/periodic counter timer controller
// Ports: clk_i, rst_i (sync active-high); cfg_valid_i/cfg_ready_o handshake
// latching cfg_start_i/cfg_periodic_i; start_i/stop_i run control;
// busy_o, tick_o (overflow pulse), done_o (one-shot end pulse), count_o.
module counter_timer_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int WORD_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cfg_valid_i,
    output logic                  cfg_ready_o,
    input  logic [WORD_WIDTH-1:0] cfg_start_i,
    input  logic                  cfg_periodic_i,
    input  logic                  start_i,
    input  logic                  stop_i,
    output logic                  busy_o,
    output logic                  tick_o,
    output logic                  done_o,
    output logic [WORD_WIDTH-1:0] count_o
);

    ctrl_state_t           state;
    ctrl_state_t           state_next;
    logic [WORD_WIDTH-1:0] start_r;
    logic                  periodic_r;
    logic                  tick_r;
    logic                  done_r;
    logic                  tick_next;
    logic                  done_next;
    logic                  cnt_action;
    logic [WORD_WIDTH-1:0] cnt_data;
    logic [WORD_WIDTH-1:0] count;
    logic                  will_ovf;

    counter_forward #(
        .WORD_WIDTH(WORD_WIDTH)
    ) u_counter (
        .clk_i          (clk_i),
        .arst_i         (1'b0),
        .action_i       (cnt_action),
        .data_i         (cnt_data),
        .data_o         (count),
        .will_overflow_o(will_ovf)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            start_r    <= '0;
            periodic_r <= 1'b0;
            tick_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state  <= state_next;
            tick_r <= tick_next;
            done_r <= done_next;
            if (cfg_valid_i && cfg_ready_o) begin
                start_r    <= cfg_start_i;
                periodic_r <= cfg_periodic_i;
            end
        end
    end

    // Counter default is hold: load its own output back.
    always_comb begin
        state_next = state;
        cnt_action = 1'b0;
        cnt_data   = count;
        tick_next  = 1'b0;
        done_next  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_i && !stop_i) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (stop_i) begin
                    state_next = IDLE;
                end else begin
                    cnt_data   = start_r;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (stop_i) begin
                    state_next = IDLE;
                end else if (will_ovf) begin
                    // Reload instead of wrapping so the period is 2^W - start.
                    cnt_data  = start_r;
                    tick_next = 1'b1;
                    if (!periodic_r) begin
                        state_next = DONE;
                        done_next  = 1'b1;
                    end
                end else begin
                    cnt_action = 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (rst_i) begin
            state_next = IDLE;
            cnt_action = 1'b0;
            cnt_data   = '0;
            tick_next  = 1'b0;
            done_next  = 1'b0;
        end
    end

    assign cfg_ready_o = (state == IDLE);
    assign busy_o      = (state != IDLE);
    assign tick_o      = tick_r;
    assign done_o      = done_r;
    assign count_o     = count;

endmodule

// File: tb/tb_counter_timer_ctrl.sv
// tb/tb_counter_timer_ctrl.sv - self-checking bench for counter_timer_ctrl
module tb_counter_timer_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       cfg_valid_i = 1'b0;
    logic       cfg_ready_o;
    logic [7:0] cfg_start_i = 8'd0;
    logic       cfg_periodic_i = 1'b0;
    logic       start_i = 1'b0;
    logic       stop_i = 1'b0;
    logic       busy_o;
    logic       tick_o;
    logic       done_o;
    logic [7:0] count_o;

    int n_tests = 0;
    int n_fail  = 0;
    int mcount  = 0;

    typedef struct packed {
        logic       busy;
        logic       tick;
        logic       done;
        logic [7:0] count;
    } exp_t;

    counter_timer_ctrl #(.WORD_WIDTH(8)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .cfg_valid_i   (cfg_valid_i),
        .cfg_ready_o   (cfg_ready_o),
        .cfg_start_i   (cfg_start_i),
        .cfg_periodic_i(cfg_periodic_i),
        .start_i       (start_i),
        .stop_i        (stop_i),
        .busy_o        (busy_o),
        .tick_o        (tick_o),
        .done_o        (done_o),
        .count_o       (count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // k counts cycles after the edge that accepted start (k=1 is the load cycle).
    // j = k-2 is the index into the run; period = 256 - s.
    function automatic exp_t model(int s, bit per, int k, int prev);
        exp_t e;
        int   p;
        int   j;
        p = 256 - s;
        j = k - 2;
        e.busy = 1'b1; e.tick = 1'b0; e.done = 1'b0;
        if (k == 1) begin
            e.count = 8'(prev);
        end else if (per) begin
            e.count = 8'(s + (j % p));
            e.tick  = (j > 0) && (j % p == 0);
        end else if (j < p) begin
            e.count = 8'(s + j);
        end else if (j == p) begin
            e.count = 8'(s); e.tick = 1'b1; e.done = 1'b1;
        end else begin
            e.count = 8'(s); e.busy = 1'b0;
        end
        return e;
    endfunction

    task automatic test_reset();
        exp_t e;
        rst_i = 1'b1; cfg_valid_i = 1'b1; cfg_start_i = 8'd99; cfg_periodic_i = 1'b1; start_i = 1'b1;
        step(); step();
        rst_i = 1'b0; cfg_valid_i = 1'b0; start_i = 1'b0;
        n_tests++;
        if ({busy_o, tick_o, done_o, count_o, cfg_ready_o} !== {3'b000, 8'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_state: got busy=%b tick=%b done=%b cnt=%0d rdy=%b, want 0 0 0 0 1",
                     busy_o, tick_o, done_o, count_o, cfg_ready_o);
        end
        // start with reset-latched config: start 0, one-shot
        start_i = 1'b1; step(); start_i = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            if (k <= 5) e = model(0, 1'b0, k, 0);
            else e = '{busy: 1'b0, tick: 1'b0, done: 1'b0, count: 8'd3};
            n_tests++;
            if ({busy_o, tick_o, done_o, count_o} !== e) begin
                n_fail++;
                $display("FAIL reset_cfg k=%0d: got busy=%b tick=%b done=%b cnt=%0d, want %b %b %b %0d",
                         k, busy_o, tick_o, done_o, count_o, e.busy, e.tick, e.done, e.count);
            end
            stop_i = (k == 5);
            step();
        end
        stop_i = 1'b0;
        // start with stop in IDLE must not launch
        start_i = 1'b1; stop_i = 1'b1; step(); start_i = 1'b0; stop_i = 1'b0;
        n_tests++;
        if (busy_o !== 1'b0 || count_o !== 8'd3) begin
            n_fail++;
            $display("FAIL start_with_stop: got busy=%b cnt=%0d, want 0 3", busy_o, count_o);
        end
        mcount = 3;
    endtask

    task automatic test_oneshot();
        exp_t e;
        cfg_valid_i = 1'b1; cfg_start_i = 8'd250; cfg_periodic_i = 1'b0;
        step(); cfg_valid_i = 1'b0;
        n_tests++;
        if (busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL cfg_no_start: got busy=%b, want 0", busy_o);
        end
        start_i = 1'b1; step(); start_i = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            e = model(250, 1'b0, k, mcount);
            n_tests++;
            if ({busy_o, tick_o, done_o, count_o} !== e || cfg_ready_o !== !e.busy) begin
                n_fail++;
                $display("FAIL oneshot k=%0d: got busy=%b tick=%b done=%b cnt=%0d rdy=%b, want %b %b %b %0d %b",
                         k, busy_o, tick_o, done_o, count_o, cfg_ready_o, e.busy, e.tick, e.done, e.count, !e.busy);
            end
            stop_i = (k == 8);  // stop during DONE has no effect
            step();
        end
        stop_i = 1'b0;
        mcount = 250;
    endtask

    task automatic test_periodic();
        exp_t e;
        int   ticks = 0;
        bit   stopped = 0;
        int   held = 0;
        cfg_valid_i = 1'b1; cfg_start_i = 8'd252; cfg_periodic_i = 1'b1; start_i = 1'b1;
        step(); cfg_valid_i = 1'b0; start_i = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            if (stopped) e = '{busy: 1'b0, tick: 1'b0, done: 1'b0, count: 8'(held)};
            else e = model(252, 1'b1, k, mcount);
            if (tick_o === 1'b1) ticks++;
            n_tests++;
            if ({busy_o, tick_o, done_o, count_o} !== e) begin
                n_fail++;
                $display("FAIL periodic k=%0d: got busy=%b tick=%b done=%b cnt=%0d, want %b %b %b %0d",
                         k, busy_o, tick_o, done_o, count_o, e.busy, e.tick, e.done, e.count);
            end
            stop_i = (k == 16);
            if (k == 16) begin stopped = 1; held = e.count; end
            step();
        end
        stop_i = 1'b0;
        n_tests++;
        if (ticks != 3) begin
            n_fail++;
            $display("FAIL periodic_ticks: got %0d, want 3", ticks);
        end
        mcount = held;
    endtask

    task automatic test_stop_at_max();
        exp_t e;
        int   s = $urandom_range(240, 254);
        int   p = 256 - s;
        int   ks = 2 * p + 1;
        bit   stopped = 0;
        int   held = 0;
        cfg_valid_i = 1'b1; cfg_start_i = 8'(s); cfg_periodic_i = 1'b1; start_i = 1'b1;
        step(); cfg_valid_i = 1'b0; start_i = 1'b0;
        for (int k = 1; k <= ks + 2; k++) begin
            if (stopped) e = '{busy: 1'b0, tick: 1'b0, done: 1'b0, count: 8'(held)};
            else e = model(s, 1'b1, k, mcount);
            n_tests++;
            if ({busy_o, tick_o, done_o, count_o} !== e) begin
                n_fail++;
                $display("FAIL stop_at_max s=%0d k=%0d: got busy=%b tick=%b done=%b cnt=%0d, want %b %b %b %0d",
                         s, k, busy_o, tick_o, done_o, count_o, e.busy, e.tick, e.done, e.count);
            end
            stop_i = (k == ks);
            if (k == ks) begin stopped = 1; held = e.count; end
            step();
        end
        stop_i = 1'b0;
        n_tests++;
        if (count_o !== 8'd255 || tick_o !== 1'b0 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_hold_255: got cnt=%0d tick=%b busy=%b, want 255 0 0", count_o, tick_o, busy_o);
        end
        mcount = 255;
    endtask

    task automatic test_allones();
        exp_t e;
        cfg_valid_i = 1'b1; cfg_start_i = 8'd255; cfg_periodic_i = 1'b0;
        step(); cfg_valid_i = 1'b0;
        start_i = 1'b1; step(); start_i = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            e = model(255, 1'b0, k, mcount);
            n_tests++;
            if ({busy_o, tick_o, done_o, count_o} !== e) begin
                n_fail++;
                $display("FAIL allones k=%0d: got busy=%b tick=%b done=%b cnt=%0d, want %b %b %b %0d",
                         k, busy_o, tick_o, done_o, count_o, e.busy, e.tick, e.done, e.count);
            end
            step();
        end
        mcount = 255;
    endtask

    task automatic test_reset_midrun();
        exp_t e;
        cfg_valid_i = 1'b1; cfg_start_i = 8'd250; cfg_periodic_i = 1'b1; start_i = 1'b1;
        step(); cfg_valid_i = 1'b0; start_i = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            e = model(250, 1'b1, k, mcount);
            n_tests++;
            if ({busy_o, tick_o, done_o, count_o} !== e) begin
                n_fail++;
                $display("FAIL rst_midrun k=%0d: got busy=%b tick=%b done=%b cnt=%0d, want %b %b %b %0d",
                         k, busy_o, tick_o, done_o, count_o, e.busy, e.tick, e.done, e.count);
            end
            if (k < 5) step();
        end
        // count is 253 here; reset overrides start, cfg and stop this cycle
        rst_i = 1'b1; start_i = 1'b1; cfg_valid_i = 1'b1; stop_i = 1'b1;
        step();
        rst_i = 1'b0; start_i = 1'b0; cfg_valid_i = 1'b0; stop_i = 1'b0;
        n_tests++;
        if ({busy_o, tick_o, done_o, count_o, cfg_ready_o} !== {3'b000, 8'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL rst_midrun_after: got busy=%b tick=%b done=%b cnt=%0d rdy=%b, want 0 0 0 0 1",
                     busy_o, tick_o, done_o, count_o, cfg_ready_o);
        end
        mcount = 0;
    endtask

    task automatic test_cfg_during_run();
        exp_t e;
        bit   stopped = 0;
        int   held = 0;
        cfg_valid_i = 1'b1; cfg_start_i = 8'd252; cfg_periodic_i = 1'b1; start_i = 1'b1;
        step(); cfg_valid_i = 1'b0; start_i = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            if (stopped) e = '{busy: 1'b0, tick: 1'b0, done: 1'b0, count: 8'(held)};
            else e = model(252, 1'b1, k, mcount);
            n_tests++;
            if ({busy_o, tick_o, done_o, count_o} !== e || cfg_ready_o !== !e.busy) begin
                n_fail++;
                $display("FAIL cfg_in_run k=%0d: got busy=%b tick=%b done=%b cnt=%0d rdy=%b, want %b %b %b %0d %b",
                         k, busy_o, tick_o, done_o, count_o, cfg_ready_o, e.busy, e.tick, e.done, e.count, !e.busy);
            end
            cfg_valid_i = (k >= 3 && k <= 6);
            cfg_start_i = 8'd100; cfg_periodic_i = 1'b0;
            stop_i = (k == 14);
            if (k == 14) begin stopped = 1; held = e.count; end
            step();
        end
        cfg_valid_i = 1'b0; stop_i = 1'b0;
        mcount = held;
    endtask

    task automatic test_random();
        exp_t e;
        for (int r = 0; r < 20; r++) begin
            int s = $urandom_range(200, 255);
            bit per = 1'($urandom_range(0, 1));
            bit same = 1'($urandom_range(0, 1));
            int p = 256 - s;
            int stop_k;
            int len;
            bit stopped = 0;
            int held = 0;
            if (per) begin
                stop_k = $urandom_range(1, 2 * p + 3);
                len = stop_k + 2;
            end else begin
                stop_k = $urandom_range(1, p + 6);
                len = p + 4;
            end
            cfg_start_i = 8'(s); cfg_periodic_i = per;
            if (!same) begin
                cfg_valid_i = 1'b1; step(); cfg_valid_i = 1'b0;
            end else begin
                cfg_valid_i = 1'b1;
            end
            start_i = 1'b1; step(); start_i = 1'b0; cfg_valid_i = 1'b0;
            for (int k = 1; k <= len; k++) begin
                if (stopped) e = '{busy: 1'b0, tick: 1'b0, done: 1'b0, count: 8'(held)};
                else e = model(s, per, k, mcount);
                n_tests++;
                if ({busy_o, tick_o, done_o, count_o} !== e || cfg_ready_o !== !e.busy) begin
                    n_fail++;
                    $display("FAIL random r=%0d s=%0d per=%0d k=%0d: got busy=%b tick=%b done=%b cnt=%0d rdy=%b, want %b %b %b %0d %b",
                             r, s, per, k, busy_o, tick_o, done_o, count_o, cfg_ready_o,
                             e.busy, e.tick, e.done, e.count, !e.busy);
                end
                stop_i = (k == stop_k) && (k < len);
                if ((k == stop_k) && (k < len)) begin stopped = 1; held = e.count; end
                step();
            end
            stop_i = 1'b0;
            mcount = e.count;
        end
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_periodic();
        test_stop_at_max();
        test_allones();
        test_reset_midrun();
        test_cfg_during_run();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
